cmp_sort_ctrl: RTL and testbench
================================

Name: cmp_sort_ctrl

Overview:
- Sequencer that shares one WIDTH-bit magnitude comparator (Greater/Equal outputs) to bubble-sort a buffered block of unsigned values.
- Values are loaded through a valid/ready input, sorted ascending in place with one comparison per cycle, then streamed out through a valid/ready output.
- Sits between a sample source and a downstream consumer that needs ordered data (max/min/median extraction).

Parameters:
- WIDTH, 4, bit width of each element and of the comparator operands.
- DEPTH, 8, buffer capacity in elements; must be ≥2.
- CW, $clog2(DEPTH+1), width of the count fields.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block accepts in_data; asserted in LOAD and count < DEPTH.
- in_data  input  WIDTH  element to store.
- start  input  1  single-cycle request to sort the loaded elements.
- busy  output  1  high in SORT and DRAIN.
- done  output  1  one-cycle pulse on the cycle after the last output beat is accepted.
- out_valid  output  1  out_data is valid (DRAIN only).
- out_ready  input  1  consumer accepts out_data.
- out_data  output  WIDTH  current sorted element, smallest first.
- count  output  CW  number of elements currently loaded.

Behaviour:
- Reset (async, rst_n=0):
  - state=LOAD; count=0; all buffer entries=0.
  - in_ready=1; busy=0; done=0; out_valid=0; out_data=0.
- LOAD:
  - On in_valid && in_ready, write buf[count] and increment count.
  - start with count≥2 → SORT with limit=count-1, idx=0, swapped=0.
  - start with count 0 or 1 → DRAIN directly, no comparisons.
  - start in the same cycle as an accepted input: the input is stored first and the new count is used.
  - start outside LOAD is ignored.
- SORT (one comparison per cycle):
  - Comparator operands: A=buf[idx], B=buf[idx+1].
  - If Greater: swap the two entries at the clock edge and set swapped=1. Equal never swaps, so the sort is stable.
  - If idx < limit-1: increment idx.
  - Otherwise the pass ends:
    - If swapped=0 or limit=1 → DRAIN with rd=0.
    - Else limit decrements, idx=0, swapped=0.
  - An already-sorted block of N elements takes exactly N-1 SORT cycles.
  - Worst case takes N(N-1)/2 SORT cycles.
- DRAIN:
  - out_valid=1; out_data=buf[rd] (combinational from rd).
  - On out_ready, increment rd.
  - When the accepted beat has rd=count-1: next cycle state=LOAD, count=0, done=1 for that one cycle.
  - count=0 case: DRAIN produces no beat; out_valid stays 0; done pulses on the cycle after entry.
  - out_data must hold while out_valid && !out_ready.
- in_ready=0 outside LOAD. Inputs presented during SORT or DRAIN are not accepted.
- Reset asserted mid-SORT or mid-DRAIN: immediate return to reset values; no partial output completes.
- No arithmetic overflow: idx, limit and rd are bounded by DEPTH-1; count saturates at DEPTH because in_ready drops.

Optional Feature:
- Macro: CMP_SORT_STATS_EN.
- Defined:
  - Extra output port swap_count, 16 bits.
  - Cleared on the cycle SORT is entered; increments on every swap.
  - Saturates at 16'hFFFF.
  - Holds its value through DRAIN and LOAD until the next sort; reset value 0.
- Undefined: the port and its counter are absent; all other behaviour is identical.

Decomposition:
- Shared package cmp_sort_pkg:
  - state encoding typedef with states LOAD, SORT, DRAIN.
  - WIDTH/DEPTH defaults.
- One sub-module, mag_cmp: purely combinational WIDTH-bit unsigned comparator with inputs A, B and outputs Greater (A>B) and Equal (A==B). It is instantiated once and is the only comparison resource.

Test Plan:
- Reset mid-operation: load 3,1,2, pulse start, assert rst_n=0 during SORT → all outputs at reset values immediately; count=0.
- Reverse order: load 7,6,5,4,3,2,1,0 (DEPTH=8), pulse start → out beats 0..7 ascending; 28 SORT cycles; done pulses once; swap_count=28 when the macro is defined.
- Already sorted: load 1,2,3,4, pulse start → exactly 3 SORT cycles; out 1,2,3,4; swap_count=0.
- Duplicates and stability: load 1,1,0,1 → out 0,1,1,1; the equal pairs (1,1) are never swapped; swap_count=2.
- Full and backpressure:
  - Offer 9 inputs with DEPTH=8 → in_ready=0 after the 8th; the 9th is not stored.
  - During DRAIN, hold out_ready=0 for 5 cycles → out_data stable and out_valid held.
- Degenerate counts:
  - start with count=0 → no beats; done pulse 2 cycles after start.
  - start with count=1 holding 5 → single beat 5, then done.
  - start during DRAIN → ignored.

Source files
------------

// File: rtl/cmp_sort_pkg.sv
// Shared definitions for the compare/sort sequencer: state encoding and
// default geometry of the element buffer.
package cmp_sort_pkg;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    SORT  = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_DEPTH = 8;

endpackage

// File: rtl/cmp_sort_ctrl_mag_cmp.sv
// Purely combinational unsigned magnitude comparator; the single compare
// resource shared by every step of the sort.
module mag_cmp
  import cmp_sort_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             Greater,
  output logic             Equal
);

  assign Greater = (A > B);
  assign Equal   = (A == B);

endmodule

// File: rtl/cmp_sort_ctrl.sv
// Bubble-sort sequencer: loads up to DEPTH unsigned elements, sorts them
// ascending in place with one shared comparator (one compare per cycle),
// then streams them out smallest first.
// Optional macro CMP_SORT_STATS_EN adds a 16-bit saturating swap_count port.
module cmp_sort_ctrl
  import cmp_sort_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    count
`ifdef CMP_SORT_STATS_EN
  ,
  output logic [15:0]      swap_count
`endif
);

  localparam int IW = $clog2(DEPTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_buf [DEPTH];
  logic [CW-1:0]    r_count;
  logic [IW-1:0]    r_idx;
  logic [IW-1:0]    r_limit;
  logic [IW-1:0]    r_rd;
  logic             r_swapped;
  logic             r_done;

  logic             w_accept;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic             w_gt;
  logic             w_eq;
  logic             w_swap;
  logic             w_sort_go;
  logic             w_drain_go;
  logic             w_pass_end;
  logic             w_beat;
  logic             w_finish;

  assign in_ready  = (r_state == LOAD) && (r_count < CW'(DEPTH));
  assign busy      = (r_state != LOAD);
  assign done      = r_done;
  assign out_valid = (r_state == DRAIN) && (r_count != '0);
  assign out_data  = out_valid ? r_buf[r_rd] : '0;
  assign count     = r_count;

  assign w_accept  = in_valid && in_ready;
  // An input accepted alongside start is counted before the sort decision.
  assign w_cnt_nxt = r_count + CW'(w_accept);
  assign w_a       = r_buf[r_idx];
  assign w_b       = r_buf[r_idx + IW'(1)];

  mag_cmp #(.WIDTH(WIDTH)) u_cmp (
    .A       (w_a),
    .B       (w_b),
    .Greater (w_gt),
    .Equal   (w_eq)
  );

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    w_state_nxt = r_state;
    w_swap      = 1'b0;
    w_sort_go   = 1'b0;
    w_drain_go  = 1'b0;
    w_pass_end  = 1'b0;
    w_beat      = 1'b0;
    w_finish    = 1'b0;
    case (r_state)
      LOAD: begin
        if (start) begin
          if (w_cnt_nxt >= CW'(2)) begin
            w_state_nxt = SORT;
            w_sort_go   = 1'b1;
          end else begin
            w_state_nxt = DRAIN;
            w_drain_go  = 1'b1;
          end
        end
      end
      SORT: begin
        // Equal operands never swap, which keeps the sort stable.
        w_swap = w_gt && !w_eq;
        if (r_idx == r_limit - IW'(1)) begin
          w_pass_end = 1'b1;
          // A swap on the last compare of a pass still demands another pass.
          if (!(r_swapped || w_swap) || (r_limit == IW'(1))) begin
            w_state_nxt = DRAIN;
            w_drain_go  = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (r_count == '0) begin
          w_finish    = 1'b1;
          w_state_nxt = LOAD;
        end else if (out_ready) begin
          w_beat = 1'b1;
          if (CW'(r_rd) == r_count - CW'(1)) begin
            w_finish    = 1'b1;
            w_state_nxt = LOAD;
          end
        end
      end
      default: w_state_nxt = LOAD;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= LOAD;
    else        r_state <= w_state_nxt;
  end

  // Sort/drain bookkeeping: element count, pass index/limit, read pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count   <= '0;
      r_idx     <= '0;
      r_limit   <= '0;
      r_rd      <= '0;
      r_swapped <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_done <= w_finish;
      if (w_finish)      r_count <= '0;
      else if (w_accept) r_count <= w_cnt_nxt;
      if (w_sort_go) begin
        r_idx     <= '0;
        r_limit   <= IW'(w_cnt_nxt - CW'(1));
        r_swapped <= 1'b0;
      end else if (r_state == SORT) begin
        if (w_pass_end) begin
          r_idx     <= '0;
          r_limit   <= r_limit - IW'(1);
          r_swapped <= 1'b0;
        end else begin
          r_idx     <= r_idx + IW'(1);
          r_swapped <= r_swapped || w_swap;
        end
      end
      if (w_drain_go)                r_rd <= '0;
      else if (w_beat && !w_finish)  r_rd <= r_rd + IW'(1);
    end
  end

  // Element buffer: written by accepted inputs in LOAD, swapped in SORT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else if (w_accept) begin
      r_buf[IW'(r_count)] <= in_data;
    end else if (w_swap) begin
      r_buf[r_idx]          <= w_b;
      r_buf[r_idx + IW'(1)] <= w_a;
    end
  end

`ifdef CMP_SORT_STATS_EN
  logic [15:0] r_swap_cnt;

  // Swap statistics: cleared on entry to SORT, saturating, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                r_swap_cnt <= '0;
    else if (w_sort_go)                        r_swap_cnt <= '0;
    else if (w_swap && r_swap_cnt != 16'hFFFF) r_swap_cnt <= r_swap_cnt + 16'd1;
  end

  assign swap_count = r_swap_cnt;
`endif

endmodule

// File: tb/tb_cmp_sort_ctrl.sv
// Directed bench for cmp_sort_ctrl (WIDTH=4, DEPTH=8).
module tb_cmp_sort_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] in_data = '0;
  logic       start = 1'b0;
  logic       busy;
  logic       done;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic [3:0] count;
`ifdef CMP_SORT_STATS_EN
  logic [15:0] swap_count;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] ev [8];

  cmp_sort_ctrl #(.WIDTH(4), .DEPTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .count     (count)
`ifdef CMP_SORT_STATS_EN
    ,
    .swap_count (swap_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [3:0] v);
    in_valid = 1'b1;
    in_data  = v;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic start_and_measure(input int exp_cyc);
    int cyc;
    cyc   = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
    while (busy && !out_valid && cyc < 100) begin
      cyc++;
      tick();
    end
    chk("sort_cycles", cyc, exp_cyc);
  endtask

  task automatic drain_expect(input int n, input logic [3:0] e [8]);
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) begin
      chk("out_valid", out_valid, 1);
      chk("out_data", out_data, e[i]);
      tick();
    end
    out_ready = 1'b0;
    chk("done_pulse", done, 1);
    chk("busy_after_drain", busy, 0);
    chk("count_cleared", count, 0);
    chk("out_valid_after", out_valid, 0);
    tick();
    chk("done_one_cycle", done, 0);
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    chk("rst_in_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_count", count, 0);
    rst_n = 1'b1;
    tick();

    // Reset asserted in the middle of a sort
    load(4'd3); load(4'd1); load(4'd2);
    chk("mid_count3", count, 3);
    start = 1'b1; tick(); start = 1'b0;
    tick();
    chk("mid_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_done", done, 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Reverse order, full buffer, 9th input refused
    for (int v = 7; v >= 0; v--) load(4'(v));
    chk("full_count", count, 8);
    chk("full_in_ready", in_ready, 0);
    in_valid = 1'b1; in_data = 4'd15;
    tick();
    in_valid = 1'b0;
    chk("ninth_not_stored", count, 8);
    start_and_measure(28);
    // Backpressure with start held (ignored while draining)
    start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_data", out_data, 0);
      chk("bp_in_ready", in_ready, 0);
      tick();
    end
    start = 1'b0;
    chk("bp_count", count, 8);
    ev = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
    drain_expect(8, ev);
`ifdef CMP_SORT_STATS_EN
    chk("rev_swaps", swap_count, 28);
`endif

    // Already sorted
    load(4'd1); load(4'd2); load(4'd3); load(4'd4);
    start_and_measure(3);
    ev = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd0, 4'd0, 4'd0, 4'd0};
    drain_expect(4, ev);
`ifdef CMP_SORT_STATS_EN
    chk("sorted_swaps", swap_count, 0);
`endif

    // Duplicates and stability
    load(4'd1); load(4'd1); load(4'd0); load(4'd1);
    start_and_measure(6);
    ev = '{4'd0, 4'd1, 4'd1, 4'd1, 4'd0, 4'd0, 4'd0, 4'd0};
    drain_expect(4, ev);
`ifdef CMP_SORT_STATS_EN
    chk("dup_swaps", swap_count, 2);
`endif

    // Start with nothing loaded
    start = 1'b1; tick(); start = 1'b0;
    chk("empty_busy", busy, 1);
    chk("empty_out_valid", out_valid, 0);
    chk("empty_done_early", done, 0);
    tick();
    chk("empty_done", done, 1);
    chk("empty_idle", busy, 0);
    tick();
    chk("empty_done_end", done, 0);

    // Single element
    load(4'd5);
    start = 1'b1; tick(); start = 1'b0;
    ev = '{4'd5, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    drain_expect(1, ev);

    // Start in the same cycle as an accepted input
    load(4'd2);
    in_valid = 1'b1; in_data = 4'd0; start = 1'b1;
    tick();
    in_valid = 1'b0; start = 1'b0;
    chk("same_cycle_count", count, 2);
    chk("same_cycle_busy", busy, 1);
    tick();
    ev = '{4'd0, 4'd2, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0};
    drain_expect(2, ev);
`ifdef CMP_SORT_STATS_EN
    chk("same_cycle_swaps", swap_count, 1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
